// File: rtl/probe_result_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : probe_result_writer
// Pops three-lane match records and writes them as 3 x 64-bit words to memory.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module probe_result_writer #(
  parameter int ADDR_WIDTH = 48,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [CNT_WIDTH-1:0]  max_results_in,
  input  logic                  input_done_in,
  input  logic                  fifo_empty_in,
  output logic                  fifo_read_en_out,
  input  logic [63:0]           fifo_data_0_in,
  input  logic [63:0]           fifo_data_1_in,
  input  logic [63:0]           fifo_data_2_in,
  output logic                  mem_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [63:0]           mem_data_out,
  input  logic                  mem_stall_in,
  output logic [CNT_WIDTH-1:0]  result_count_out,
  output logic                  overflow_out,
  output logic                  done_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_LOAD = 3'd2,
    S_WR0  = 3'd3,
    S_WR1  = 3'd4,
    S_WR2  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_word_bytes = ADDR_WIDTH'(8);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_offset;
  logic [CNT_WIDTH-1:0]  r_capacity;
  logic [63:0]           r_data_1;
  logic [63:0]           r_data_2;

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_next_offset;

  assign w_accept      = mem_req_out && !mem_stall_in;
  assign w_next_offset = r_offset + c_word_bytes;

  // The pop must be gated by the live empty flag, so it cannot be registered.
  assign fifo_read_en_out = (r_state == S_WAIT) && !fifo_empty_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_base           <= '0;
      r_offset         <= '0;
      r_capacity       <= '0;
      r_data_1         <= '0;
      r_data_2         <= '0;
      mem_req_out      <= 1'b0;
      mem_addr_out     <= '0;
      mem_data_out     <= '0;
      result_count_out <= '0;
      overflow_out     <= 1'b0;
      done_out         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_in) begin
            r_base           <= base_addr_in;
            r_capacity       <= max_results_in;
            r_offset         <= '0;
            result_count_out <= '0;
            overflow_out     <= 1'b0;
            done_out         <= 1'b0;
            r_state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!fifo_empty_in) begin
            r_state <= S_LOAD;
          end else if (input_done_in) begin
            done_out <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_LOAD: begin
          // Lane 0 goes straight to the write-data register; lanes 1/2 wait.
          if (result_count_out == r_capacity) begin
            overflow_out <= 1'b1;
            r_state      <= S_WAIT;
          end else begin
            r_data_1     <= fifo_data_1_in;
            r_data_2     <= fifo_data_2_in;
            mem_req_out  <= 1'b1;
            mem_addr_out <= r_base + r_offset;
            mem_data_out <= fifo_data_0_in;
            r_state      <= S_WR0;
          end
        end
        S_WR0: begin
          if (w_accept) begin
            r_offset     <= w_next_offset;
            mem_addr_out <= r_base + w_next_offset;
            mem_data_out <= r_data_1;
            r_state      <= S_WR1;
          end
        end
        S_WR1: begin
          if (w_accept) begin
            r_offset     <= w_next_offset;
            mem_addr_out <= r_base + w_next_offset;
            mem_data_out <= r_data_2;
            r_state      <= S_WR2;
          end
        end
        S_WR2: begin
          if (w_accept) begin
            r_offset         <= w_next_offset;
            mem_req_out      <= 1'b0;
            result_count_out <= result_count_out + CNT_WIDTH'(1);
            r_state          <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_probe_result_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_probe_result_writer
// Scoreboard bench: stimulus queues expected writes, a monitor pops/compares.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_probe_result_writer;
  localparam int AW = 48;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in;
  logic [AW-1:0] base_addr_in;
  logic [CW-1:0] max_results_in;
  logic          input_done_in;
  logic          fifo_empty_in;
  logic          fifo_read_en_out;
  logic [63:0]   fifo_data_0_in;
  logic [63:0]   fifo_data_1_in;
  logic [63:0]   fifo_data_2_in;
  logic          mem_req_out;
  logic [AW-1:0] mem_addr_out;
  logic [63:0]   mem_data_out;
  logic          mem_stall_in;
  logic [CW-1:0] result_count_out;
  logic          overflow_out;
  logic          done_out;

  probe_result_writer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .base_addr_in(base_addr_in),
    .max_results_in(max_results_in), .input_done_in(input_done_in),
    .fifo_empty_in(fifo_empty_in), .fifo_read_en_out(fifo_read_en_out),
    .fifo_data_0_in(fifo_data_0_in), .fifo_data_1_in(fifo_data_1_in),
    .fifo_data_2_in(fifo_data_2_in), .mem_req_out(mem_req_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_stall_in(mem_stall_in), .result_count_out(result_count_out),
    .overflow_out(overflow_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          stall_seen = 0;
  int          cyc = 0;
  int          pop_cyc = 0;
  logic        prev_req = 1'b0;

  // Standard (non-FWFT) FIFO model: data appears the cycle after the pop.
  logic [63:0] fifo_l0 [0:31];
  logic [63:0] fifo_l1 [0:31];
  logic [63:0] fifo_l2 [0:31];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  assign fifo_empty_in = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read_en_out && !fifo_empty_in) begin
      fifo_data_0_in <= fifo_l0[rd_ptr];
      fifo_data_1_in <= fifo_l1[rd_ptr];
      fifo_data_2_in <= fifo_l2[rd_ptr];
      rd_ptr         <= rd_ptr + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented write against the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (fifo_read_en_out) begin
        check("pop_while_empty", fifo_empty_in, 1'b0);
        pop_cyc = cyc;
      end
      if (mem_req_out && !prev_req)
        check("first_req_latency", 64'(cyc - pop_cyc), 64'd2);
      prev_req = mem_req_out;
      if (mem_req_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", mem_addr_out, 64'hDEAD_BEEF);
        end else begin
          check("write_addr", 64'(mem_addr_out), 64'(exp_q[0].addr));
          check("write_data", mem_data_out, exp_q[0].data);
          if (!mem_stall_in) void'(exp_q.pop_front());
        end
        if (mem_stall_in) stall_seen++;
      end
    end
  end

  task automatic push_rec(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    fifo_l0[wr_ptr] = a;
    fifo_l1[wr_ptr] = b;
    fifo_l2[wr_ptr] = c;
    wr_ptr++;
  endtask

  task automatic expect_rec(input logic [AW-1:0] addr, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] c);
    logic [AW-1:0] a1, a2;
    a1 = addr + 48'd8;
    a2 = addr + 48'd16;
    exp_q.push_back('{addr: addr, data: a});
    exp_q.push_back('{addr: a1, data: b});
    exp_q.push_back('{addr: a2, data: c});
  endtask

  task automatic start_run(input logic [AW-1:0] base, input logic [CW-1:0] cap);
    @(negedge clk);
    base_addr_in   = base;
    max_results_in = cap;
    start_in       = 1'b1;
    @(negedge clk);
    start_in       = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300; i++) begin
      if (done_out) break;
      @(negedge clk);
    end
    check(name, done_out, 1'b1);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_addr(input logic [AW-1:0] addr);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mem_req_out && mem_addr_out == addr) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait_for_addr", found, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_in = 1'b0; base_addr_in = '0; max_results_in = '0;
    input_done_in = 1'b0; mem_stall_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", mem_req_out, 0);
    check("rst_addr", 64'(mem_addr_out), 0);
    check("rst_data", mem_data_out, 0);
    check("rst_count", 64'(result_count_out), 0);
    check("rst_overflow", overflow_out, 0);
    check("rst_done", done_out, 0);
    check("rst_pop", fifo_read_en_out, 0);
    rst = 1'b0;

    // Not started: no pop and no done even with input_done high.
    input_done_in = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle_pop", fifo_read_en_out, 0);
      check("idle_done", done_out, 0);
    end

    // Single record, no stall.
    input_done_in = 1'b0;
    push_rec(64'hA, 64'hB, 64'hC);
    expect_rec(48'h1000, 64'hA, 64'hB, 64'hC);
    start_run(48'h1000, 32'd4);
    input_done_in = 1'b1;
    wait_done("basic_done");
    check("basic_count", 64'(result_count_out), 1);
    check("basic_overflow", overflow_out, 0);

    // Same record with a 3-cycle stall on the second word; restart from DONE.
    input_done_in = 1'b0;
    push_rec(64'hA, 64'hB, 64'hC);
    expect_rec(48'h1000, 64'hA, 64'hB, 64'hC);
    start_run(48'h1000, 32'd4);
    check("restart_done_clear", done_out, 0);
    check("restart_count_clear", 64'(result_count_out), 0);
    input_done_in = 1'b1;
    wait_addr(48'h1008);
    stall_seen = 0;
    mem_stall_in = 1'b1;
    repeat (3) @(negedge clk);
    mem_stall_in = 1'b0;
    wait_done("stall_done");
    check("stall_cycles", 64'(stall_seen), 3);
    check("stall_count", 64'(result_count_out), 1);

    // Capacity 2 with 3 records: third is popped and discarded.
    input_done_in = 1'b0;
    push_rec(64'h11, 64'h12, 64'h13);
    push_rec(64'h21, 64'h22, 64'h23);
    push_rec(64'h31, 64'h32, 64'h33);
    expect_rec(48'h1000, 64'h11, 64'h12, 64'h13);
    expect_rec(48'h1018, 64'h21, 64'h22, 64'h23);
    start_run(48'h1000, 32'd2);
    input_done_in = 1'b1;
    wait_done("cap_done");
    check("cap_count", 64'(result_count_out), 2);
    check("cap_overflow", overflow_out, 1);
    check("cap_fifo_empty", fifo_empty_in, 1);

    // Address wrap at the top of the address space.
    input_done_in = 1'b0;
    push_rec(64'h5151, 64'h5252, 64'h5353);
    expect_rec(48'hFFFF_FFFF_FFF8, 64'h5151, 64'h5252, 64'h5353);
    start_run(48'hFFFF_FFFF_FFF8, 32'd4);
    check("wrap_overflow_clear", overflow_out, 0);
    input_done_in = 1'b1;
    wait_done("wrap_done");
    check("wrap_count", 64'(result_count_out), 1);

    // Capacity 0: every record discarded.
    input_done_in = 1'b0;
    push_rec(64'h77, 64'h78, 64'h79);
    start_run(48'h4000, 32'd0);
    input_done_in = 1'b1;
    wait_done("cap0_done");
    check("cap0_count", 64'(result_count_out), 0);
    check("cap0_overflow", overflow_out, 1);
    check("cap0_fifo_empty", fifo_empty_in, 1);

    // Asynchronous reset while the second word is stalled.
    input_done_in = 1'b0;
    push_rec(64'h91, 64'h92, 64'h93);
    expect_rec(48'h1000, 64'h91, 64'h92, 64'h93);
    start_run(48'h1000, 32'd4);
    wait_addr(48'h1008);
    mem_stall_in = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_req", mem_req_out, 0);
    check("arst_count", 64'(result_count_out), 0);
    check("arst_done", done_out, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_stall_in = 1'b0;
    push_rec(64'hE1, 64'hE2, 64'hE3);
    expect_rec(48'h3000, 64'hE1, 64'hE2, 64'hE3);
    start_run(48'h3000, 32'd4);
    check("arst_restart_count", 64'(result_count_out), 0);
    input_done_in = 1'b1;
    wait_done("arst_done_after");
    check("arst_final_count", 64'(result_count_out), 1);
    check("arst_final_overflow", overflow_out, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
